// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;
  localparam int STALL_W = 6;

  // Bit positions in the stall/flush vectors
  localparam int S_PC    = 0;
  localparam int S_IFID  = 1;
  localparam int S_IDEX  = 2;
  localparam int S_EXMEM = 3;
  localparam int S_MEMWB = 4;
  localparam int S_WB    = 5;

  typedef logic [STALL_W-1:0] stall_t;

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_PEND = 1'b1
  } ctrl_state_e;

  // A stall request holds its own stage and everything upstream of it
  localparam stall_t STALL_RDY = 6'b111111;
  localparam stall_t STALL_MEM = 6'b011111;
  localparam stall_t STALL_EX  = 6'b001111;
  localparam stall_t STALL_ID  = 6'b000111;
  localparam stall_t STALL_IF  = 6'b000011;
endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Saturating event counter; counts only while the chip is ready.
module perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rdy && inc && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall priority, jump redirect (immediate or
// deferred until the fetch completes) and perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              ex_jump_flag,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  output logic [5:0]        stall,
  output logic [5:0]        flush,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  output logic [CNT_W-1:0]  perf_stall_cycles,
  output logic [CNT_W-1:0]  perf_redirects
);
  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  stall_t            st, fl;
  logic              redir;
  logic [ADDR_W-1:0] redir_addr;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    st          = '0;
    fl          = '0;
    redir       = 1'b0;
    redir_addr  = '0;
    if (!rdy) begin
      st = STALL_RDY;
    end else begin
      // While a jump is pending the ID instruction is wrong-path, so its hazard is moot
      if (stallreq_mem)                               st = STALL_MEM;
      else if (stallreq_ex)                           st = STALL_EX;
      else if (stallreq_id && state_q == CTRL_IDLE)   st = STALL_ID;
      else if (stallreq_if)                           st = STALL_IF;

      case (state_q)
        CTRL_IDLE: begin
          if (ex_jump_flag && !st[S_EXMEM]) begin
            if (!stallreq_if) begin
              redir       = 1'b1;
              redir_addr  = ex_jump_addr;
              fl[S_IFID]  = 1'b1;
              fl[S_IDEX]  = 1'b1;
            end else begin
              pend_addr_d = ex_jump_addr;
              fl[S_IDEX]  = 1'b1;
              state_d     = CTRL_PEND;
            end
          end
        end
        CTRL_PEND: begin
          fl[S_IDEX] = 1'b1;
          if (!stallreq_if && !stallreq_mem) begin
            redir      = 1'b1;
            redir_addr = pend_addr_q;
            fl[S_IFID] = 1'b1;
            state_d    = CTRL_IDLE;
          end
        end
        default: state_d = CTRL_IDLE;
      endcase

      st = st & ~fl;
      if (redir) st[S_PC] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CTRL_IDLE;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign stall            = rst ? st : '0;
  assign flush            = rst ? fl : '0;
  assign pc_redirect      = rst & redir;
  assign pc_redirect_addr = rst ? redir_addr : '0;

  perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk(clk), .rst(rst), .rdy(rdy), .inc(|stall[S_MEMWB:S_IFID]), .cnt(perf_stall_cycles)
  );

  perf_cnt #(.CNT_W(CNT_W)) u_cnt_redir (
    .clk(clk), .rst(rst), .rdy(rdy), .inc(pc_redirect), .cnt(perf_redirects)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: hand-derived vector table, directed PEND/reset/saturation
// sequences, then random stimulus against a behavioural model.
module tb_pipe_ctrl;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst, rdy, sif, sid, sex, smem, jf;
  logic [31:0] ja;
  logic [5:0]  stall, flush;
  logic        redir;
  logic [31:0] raddr;
  logic [CNT_W-1:0] pstall, predir;

  pipe_ctrl #(.CNT_W(CNT_W), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .ex_jump_flag(jf), .ex_jump_addr(ja),
    .stall(stall), .flush(flush), .pc_redirect(redir), .pc_redirect_addr(raddr),
    .perf_stall_cycles(pstall), .perf_redirects(predir)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: a jump is either pending (with its target) or not; counters as ints
  bit          m_pend  = 1'b0;
  logic [31:0] m_paddr = '0;
  int          m_cs    = 0;
  int          m_cr    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit rd, input bit i, input bit d, input bit e,
                      input bit m, input bit jfl, input logic [31:0] a,
                      input bit use_t, input logic [5:0] ts, input logic [5:0] tf,
                      input bit tr, input logic [31:0] ta);
    logic [5:0]  es, ef;
    bit          er, np;
    logic [31:0] ea, npa;
    assert (!(m_pend && jfl && r)) else $error("jump driven while a jump is pending");
    rst = r; rdy = rd; sif = i; sid = d; sex = e; smem = m; jf = jfl; ja = a;
    #1;
    es = '0; ef = '0; er = 1'b0; ea = '0; np = m_pend; npa = m_paddr;
    if (!r) begin
      np = 1'b0;
    end else if (!rd) begin
      es = 6'h3F;
    end else begin
      if (m)                es = 6'h1F;
      else if (e)           es = 6'h0F;
      else if (d && !m_pend) es = 6'h07;
      else if (i)           es = 6'h03;
      if (m_pend) begin
        ef = 6'h04;
        if (!i && !m) begin er = 1'b1; ea = m_paddr; ef = 6'h06; np = 1'b0; end
      end else if (jfl && !es[3]) begin
        if (!i) begin er = 1'b1; ea = a; ef = 6'h06; end
        else begin ef = 6'h04; np = 1'b1; npa = a; end
      end
      es = es & ~ef;
      if (er) es[0] = 1'b0;
    end
    chk("stall", {26'd0, stall}, {26'd0, es});
    chk("flush", {26'd0, flush}, {26'd0, ef});
    chk("redirect", {31'd0, redir}, {31'd0, er});
    chk("redirect_addr", raddr, ea);
    if (use_t) begin
      chk("tbl_stall", {26'd0, stall}, {26'd0, ts});
      chk("tbl_flush", {26'd0, flush}, {26'd0, tf});
      chk("tbl_redirect", {31'd0, redir}, {31'd0, tr});
      if (tr) chk("tbl_redirect_addr", raddr, ta);
    end
    @(posedge clk);
    #1;
    if (!r) begin
      m_cs = 0; m_cr = 0;
    end else if (rd) begin
      if ((|es[4:1]) && m_cs < SAT) m_cs++;
      if (er && m_cr < SAT) m_cr++;
    end
    m_pend = np; m_paddr = npa;
    chk("perf_stall_cycles", {28'd0, pstall}, m_cs);
    chk("perf_redirects", {28'd0, predir}, m_cr);
  endtask

  task automatic go(input bit r, input bit rd, input bit i, input bit d, input bit e,
                    input bit m, input bit jfl, input logic [31:0] a);
    step(r, rd, i, d, e, m, jfl, a, 1'b0, 6'h0, 6'h0, 1'b0, 32'h0);
  endtask

  task automatic gox(input bit rd, input bit i, input bit d, input bit e, input bit m,
                     input bit jfl, input logic [31:0] a, input logic [5:0] ts,
                     input logic [5:0] tf, input bit tr, input logic [31:0] ta);
    step(1'b1, rd, i, d, e, m, jfl, a, 1'b1, ts, tf, tr, ta);
  endtask

  typedef struct {
    bit rd, i, d, e, m, jf;
    logic [31:0] a;
    logic [5:0]  s, f;
    bit          r;
    logic [31:0] ra;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 32'h0,   6'h00, 6'h00, 0, 32'h0};
    tbl[1]  = '{1, 0, 1, 0, 1, 0, 32'h0,   6'h1F, 6'h00, 0, 32'h0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 32'h0,   6'h3F, 6'h00, 0, 32'h0};
    tbl[3]  = '{0, 1, 1, 1, 1, 1, 32'h300, 6'h3F, 6'h00, 0, 32'h0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 32'h0,   6'h03, 6'h00, 0, 32'h0};
    tbl[5]  = '{1, 0, 1, 0, 0, 0, 32'h0,   6'h07, 6'h00, 0, 32'h0};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 32'h0,   6'h0F, 6'h00, 0, 32'h0};
    tbl[7]  = '{1, 0, 0, 1, 0, 1, 32'h400, 6'h0F, 6'h00, 0, 32'h0};
    tbl[8]  = '{1, 0, 0, 0, 0, 1, 32'h100, 6'h00, 6'h06, 1, 32'h100};
    tbl[9]  = '{1, 0, 1, 0, 0, 1, 32'h180, 6'h00, 6'h06, 1, 32'h180};
    tbl[10] = '{1, 0, 0, 0, 1, 1, 32'h500, 6'h1F, 6'h00, 0, 32'h0};

    // Reset with random requests: everything quiet
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'b0, $urandom, 1'b1, 6'h00, 6'h00, 1'b0, 32'h0);
    chk("rst_cnt_stall", {28'd0, pstall}, 32'd0);
    chk("rst_cnt_redir", {28'd0, predir}, 32'd0);

    // Vector table from IDLE
    for (int k = 0; k < 11; k++)
      gox(tbl[k].rd, tbl[k].i, tbl[k].d, tbl[k].e, tbl[k].m, tbl[k].jf, tbl[k].a,
          tbl[k].s, tbl[k].f, tbl[k].r, tbl[k].ra);

    // Deferred jump: IF busy for 3 cycles, then redirect to 0x200
    gox(1, 1, 0, 0, 0, 1, 32'h200, 6'h03, 6'h04, 0, 32'h0);
    gox(1, 1, 0, 0, 0, 0, 32'h0,   6'h03, 6'h04, 0, 32'h0);
    gox(1, 1, 1, 0, 0, 0, 32'h0,   6'h03, 6'h04, 0, 32'h0);
    gox(1, 0, 0, 0, 1, 0, 32'h0,   6'h1B, 6'h04, 0, 32'h0);
    gox(0, 0, 0, 0, 0, 0, 32'h0,   6'h3F, 6'h00, 0, 32'h0);
    gox(1, 0, 0, 0, 0, 0, 32'h0,   6'h00, 6'h06, 1, 32'h200);
    gox(1, 0, 0, 0, 0, 0, 32'h0,   6'h00, 6'h00, 0, 32'h0);

    // Reset while pending drops the jump
    gox(1, 1, 0, 0, 0, 1, 32'h240, 6'h03, 6'h04, 0, 32'h0);
    step(1'b0, 1, 1, 0, 0, 0, 0, 32'h0, 1'b1, 6'h00, 6'h00, 1'b0, 32'h0);
    gox(1, 0, 0, 0, 0, 0, 32'h0,   6'h00, 6'h00, 0, 32'h0);
    gox(1, 0, 0, 0, 0, 0, 32'h0,   6'h00, 6'h00, 0, 32'h0);

    // Saturation of the stall counter
    go(1'b0, 1, 0, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < (1 << CNT_W) + 2; k++)
      gox(1, 0, 0, 1, 0, 0, 32'h0, 6'h0F, 6'h00, 0, 32'h0);
    chk("stall_cnt_saturated", {28'd0, pstall}, 32'hF);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      bit r_, rd_, jf_;
      r_  = ($urandom % 40) != 0;
      rd_ = ($urandom % 8) != 0;
      jf_ = !m_pend && (($urandom % 3) == 0);
      go(r_, rd_, ($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
         ($urandom % 7) == 0, jf_, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
